// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_pkg
// Purpose  : Shared constants and types for the up/down modulo-N counter.
// Revision : 1.0  initial release
// ============================================================================
package counter_pkg;

  // Behaviour at the range ends
  localparam bit COUNT_WRAP = 1'b0;
  localparam bit COUNT_SAT  = 1'b1;

  // Meaning of the M (direction) input
  localparam bit DIR_UP     = 1'b1;
  localparam bit DIR_DOWN   = 1'b0;

  // Action taken by the counter register at the next CP edge
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_COUNT = 2'd1,
    OP_LOAD  = 2'd2
  } cnt_op_t;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/updown_modcounter_if.sv
`default_nettype none
// ============================================================================
// Module   : updown_modcounter_if
// Purpose  : Control / data / cascade bundle of one counter stage.
//            master = whoever drives the stage, slave = the counter itself.
// Revision : 1.0  initial release
// ============================================================================
interface updown_modcounter_if #(
  parameter int W = 4
);
  logic         _LD;   // synchronous parallel load, active-low
  logic         EN;    // count enable
  logic         CI;    // cascade carry-in
  logic         M;     // direction, 1 = up
  logic [W-1:0] D;     // parallel load data
  logic [W-1:0] Q;     // current count
  logic         CO;    // combinational cascade carry-out
  logic         _Qcc;  // registered terminal-count strobe, active-low

  modport master (
    output _LD, EN, CI, M, D,
    input  Q, CO, _Qcc
  );

  modport slave (
    input  _LD, EN, CI, M, D,
    output Q, CO, _Qcc
  );
endinterface : updown_modcounter_if
`default_nettype wire

// File: rtl/tc_detect.sv
`default_nettype none
// ============================================================================
// Module   : tc_detect
// Purpose  : Combinational terminal-state and next-value generator for the
//            up/down modulo-N counter. All arithmetic is W+1 bits wide, so a
//            full-width modulus of 2^W never overflows.
// Revision : 1.0  initial release
// ============================================================================
module tc_detect
  import counter_pkg::*;
#(
  parameter int W   = 4,
  parameter int MOD = 16
) (
  input  logic [W-1:0] i_q,       // present count
  input  logic         i_m,       // direction
  input  logic [W-1:0] i_d,       // raw load data
  output logic         o_term,    // present count is the terminal state
  output logic [W-1:0] o_step,    // count +/- 1 (valid when not terminal)
  output logic [W-1:0] o_wrap,    // value entered when wrapping off the end
  output logic [W-1:0] o_ld_val   // load data clamped to MOD-1
);

  localparam logic [W:0] c_MOD  = (W+1)'(MOD);
  localparam logic [W:0] c_MAX  = (W+1)'(MOD - 1);
  localparam logic [W:0] c_ONE  = (W+1)'(1);
  localparam logic [W:0] c_ZERO = '0;

  logic [W:0] w_q1;
  logic [W:0] w_d1;
  logic [W:0] w_sum;

  assign w_q1 = {1'b0, i_q};
  assign w_d1 = {1'b0, i_d};

  // Step in the selected direction; the up-terminal test uses the carry bit
  always_comb begin
    w_sum  = (i_m == DIR_UP) ? (w_q1 + c_ONE) : (w_q1 - c_ONE);
    o_step = w_sum[W-1:0];
    if (i_m == DIR_UP) begin
      o_term = (w_sum == c_MOD);
      o_wrap = '0;
    end else begin
      o_term = (w_q1 == c_ZERO);
      o_wrap = c_MAX[W-1:0];
    end
  end

  // Out-of-range load data is clamped to the top of the range
  always_comb begin
    o_ld_val = (w_d1 < c_MOD) ? i_d : c_MAX[W-1:0];
  end

endmodule : tc_detect
`default_nettype wire

// File: rtl/updown_modcounter.sv
`default_nettype none
// ============================================================================
// Module   : updown_modcounter
// Purpose  : Parametrised synchronous up/down modulo-MOD counter with
//            synchronous load, enable, carry-in/carry-out cascade and
//            selectable wrap or saturate behaviour at the range ends.
//            Holds the Q and _Qcc registers; arithmetic lives in tc_detect.
// Revision : 1.0  initial release
// ============================================================================
module updown_modcounter
  import counter_pkg::*;
#(
  parameter int W    = 4,
  parameter int MOD  = 16,
  parameter int INIT = 0,
  parameter int SAT  = 0
) (
  input  logic                CP,    // clock, rising edge
  input  logic                _CLR,  // asynchronous clear, active-low
  updown_modcounter_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  generate
    if (W < 1 || W > 16) begin : g_bad_width
      $error("updown_modcounter: W=%0d outside 1..16", W);
    end
    if (MOD < 2 || MOD > (1 << W)) begin : g_bad_mod
      $error("updown_modcounter: MOD=%0d outside 2..2^W", MOD);
    end
    if (INIT < 0 || INIT >= MOD) begin : g_bad_init
      $error("updown_modcounter: INIT=%0d not below MOD=%0d", INIT, MOD);
    end
  endgenerate

  localparam logic [W-1:0] c_INIT = W'(INIT);
  localparam bit           c_SAT  = (SAT != 0) ? COUNT_SAT : COUNT_WRAP;

  logic [W-1:0] r_q;
  logic         r_qcc;

  logic         w_term;
  logic [W-1:0] w_step;
  logic [W-1:0] w_wrap;
  logic [W-1:0] w_ld_val;
  logic [W-1:0] w_next;
  logic         w_co;
  cnt_op_t      w_op;

  tc_detect #(
    .W   (W),
    .MOD (MOD)
  ) u_tc_detect (
    .i_q      (r_q),
    .i_m      (bus.M),
    .i_d      (bus.D),
    .o_term   (w_term),
    .o_step   (w_step),
    .o_wrap   (w_wrap),
    .o_ld_val (w_ld_val)
  );

  // Carry-out is purely combinational so a chained stage sees it this cycle
  assign w_co = bus.EN & bus.CI & w_term;

  // Decide the register action: load beats count, count beats hold
  always_comb begin
    w_op = OP_HOLD;
    if (!bus._LD) begin
      w_op = OP_LOAD;
    end else if (bus.EN && bus.CI) begin
      w_op = OP_COUNT;
    end
  end

  // Next count value when counting: step, or wrap/hold at the terminal state
  always_comb begin
    w_next = w_step;
    if (w_term) begin
      w_next = (c_SAT == COUNT_SAT) ? r_q : w_wrap;
    end
  end

  // Count / strobe registers with asynchronous clear to INIT
  always_ff @(posedge CP or negedge _CLR) begin
    if (!_CLR) begin
      r_q   <= c_INIT;
      r_qcc <= 1'b1;
    end else begin
      case (w_op)
        OP_LOAD: begin
          r_q   <= w_ld_val;
          r_qcc <= 1'b1;
        end
        OP_COUNT: begin
          r_q   <= w_next;
          r_qcc <= ~w_co;
        end
        default: begin
          r_q   <= r_q;
          r_qcc <= ~w_co;
        end
      endcase
    end
  end

  assign bus.Q    = r_q;
  assign bus.CO   = w_co;
  assign bus._Qcc = r_qcc;

endmodule : updown_modcounter
`default_nettype wire

// File: tb/tb_updown_modcounter.sv
`default_nettype none
// ============================================================================
// Module   : tb_updown_modcounter
// Purpose  : Self-checking bench for updown_modcounter. Six instances:
//            0 wrap MOD10, 1 saturate MOD10, 2 wrap MOD10 INIT2,
//            3 wrap MOD16 (full width), 4/5 units/tens cascade MOD10.
// Revision : 1.0  initial release
// ============================================================================
module tb_updown_modcounter;

  localparam int N = 6;

  logic CP = 1'b0;
  logic clr_n;
  bit   chk_on = 1'b0;

  int   n_pass  = 0;
  int   n_total = 0;

  always #5 CP = ~CP;

  // Per-instance stimulus
  logic       ld_n [N];
  logic       en   [N];
  logic       ci   [N];
  logic       m    [N];
  logic [3:0] d    [N];

  // Per-instance observed outputs
  logic [3:0] dq   [N];
  logic       dco  [N];
  logic       dqcc [N];

  updown_modcounter_if #(.W(4)) if0 ();
  updown_modcounter_if #(.W(4)) if1 ();
  updown_modcounter_if #(.W(4)) if2 ();
  updown_modcounter_if #(.W(4)) if3 ();
  updown_modcounter_if #(.W(4)) if4 ();
  updown_modcounter_if #(.W(4)) if5 ();

  assign if0._LD = ld_n[0]; assign if0.EN = en[0]; assign if0.CI = ci[0];
  assign if0.M   = m[0];    assign if0.D  = d[0];
  assign if1._LD = ld_n[1]; assign if1.EN = en[1]; assign if1.CI = ci[1];
  assign if1.M   = m[1];    assign if1.D  = d[1];
  assign if2._LD = ld_n[2]; assign if2.EN = en[2]; assign if2.CI = ci[2];
  assign if2.M   = m[2];    assign if2.D  = d[2];
  assign if3._LD = ld_n[3]; assign if3.EN = en[3]; assign if3.CI = ci[3];
  assign if3.M   = m[3];    assign if3.D  = d[3];
  assign if4._LD = ld_n[4]; assign if4.EN = en[4]; assign if4.CI = ci[4];
  assign if4.M   = m[4];    assign if4.D  = d[4];
  assign if5._LD = ld_n[5]; assign if5.EN = en[5]; assign if5.CI = if4.CO;
  assign if5.M   = m[5];    assign if5.D  = d[5];

  assign dq[0] = if0.Q; assign dco[0] = if0.CO; assign dqcc[0] = if0._Qcc;
  assign dq[1] = if1.Q; assign dco[1] = if1.CO; assign dqcc[1] = if1._Qcc;
  assign dq[2] = if2.Q; assign dco[2] = if2.CO; assign dqcc[2] = if2._Qcc;
  assign dq[3] = if3.Q; assign dco[3] = if3.CO; assign dqcc[3] = if3._Qcc;
  assign dq[4] = if4.Q; assign dco[4] = if4.CO; assign dqcc[4] = if4._Qcc;
  assign dq[5] = if5.Q; assign dco[5] = if5.CO; assign dqcc[5] = if5._Qcc;

  updown_modcounter #(.W(4), .MOD(10), .INIT(0), .SAT(0)) u_wrap  (.CP(CP), ._CLR(clr_n), .bus(if0));
  updown_modcounter #(.W(4), .MOD(10), .INIT(0), .SAT(1)) u_sat   (.CP(CP), ._CLR(clr_n), .bus(if1));
  updown_modcounter #(.W(4), .MOD(10), .INIT(2), .SAT(0)) u_init2 (.CP(CP), ._CLR(clr_n), .bus(if2));
  updown_modcounter #(.W(4), .MOD(16), .INIT(0), .SAT(0)) u_full  (.CP(CP), ._CLR(clr_n), .bus(if3));
  updown_modcounter #(.W(4), .MOD(10), .INIT(0), .SAT(0)) u_units (.CP(CP), ._CLR(clr_n), .bus(if4));
  updown_modcounter #(.W(4), .MOD(10), .INIT(0), .SAT(0)) u_tens  (.CP(CP), ._CLR(clr_n), .bus(if5));

  // --------------------------------------------------------------------------
  // Behavioural model: integer count per instance
  // --------------------------------------------------------------------------
  int mods  [N] = '{10, 10, 10, 16, 10, 10};
  bit sats  [N] = '{0, 1, 0, 0, 0, 0};
  int inits [N] = '{0, 0, 2, 0, 0, 0};
  int qm    [N];
  bit qccm  [N];
  bit co_s  [N];
  bit ci_s  [N];

  function automatic bit at_end(int i);
    return m[i] ? (qm[i] == mods[i] - 1) : (qm[i] == 0);
  endfunction

  function automatic bit eff_ci(int i);
    if (i == 5) return en[4] & ci[4] & at_end(4);
    return ci[i];
  endfunction

  function automatic bit model_co(int i);
    return en[i] & eff_ci(i) & at_end(i);
  endfunction

  always @(posedge CP or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < N; i++) begin
        qm[i]   = inits[i];
        qccm[i] = 1'b1;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        co_s[i] = model_co(i);
        ci_s[i] = eff_ci(i);
      end
      for (int i = 0; i < N; i++) begin
        if (!ld_n[i]) begin
          qm[i]   = (int'(d[i]) < mods[i]) ? int'(d[i]) : mods[i] - 1;
          qccm[i] = 1'b1;
        end else begin
          if (en[i] && ci_s[i]) begin
            if (m[i]) begin
              if (qm[i] == mods[i] - 1) qm[i] = sats[i] ? qm[i] : 0;
              else                      qm[i] = qm[i] + 1;
            end else begin
              if (qm[i] == 0) qm[i] = sats[i] ? 0 : mods[i] - 1;
              else            qm[i] = qm[i] - 1;
            end
          end
          qccm[i] = ~co_s[i];
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge CP) begin
    if (chk_on) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("model_q%0d", i),   int'(dq[i]),   qm[i]);
        check($sformatf("model_co%0d", i),  int'(dco[i]),  int'(model_co(i)));
        check($sformatf("model_qcc%0d", i), int'(dqcc[i]), int'(qccm[i]));
      end
    end
  end

  task automatic edge_wait();
    @(posedge CP);
    #2;
  endtask

  // --------------------------------------------------------------------------
  // Directed stimulus with hand-computed expectations
  // --------------------------------------------------------------------------
  initial begin
    int exp_q [5];
    int exp_qcc [5];

    clr_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      ld_n[i] = 1'b1; en[i] = 1'b0; ci[i] = 1'b0; m[i] = 1'b1; d[i] = 4'd0;
    end
    edge_wait();
    edge_wait();
    clr_n  = 1'b1;
    chk_on = 1'b1;

    // Reset values
    check("rst_q0",   int'(dq[0]),   0);
    check("rst_q2",   int'(dq[2]),   2);
    check("rst_qcc0", int'(dqcc[0]), 1);
    check("rst_co0",  int'(dco[0]),  0);

    // Wrap up-count 0..9,0,1,2
    en[0] = 1'b1; ci[0] = 1'b1; m[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      edge_wait();
      check($sformatf("up_q_e%0d", k),   int'(dq[0]),   k % 10);
      check($sformatf("up_co_e%0d", k),  int'(dco[0]),  ((k % 10) == 9) ? 1 : 0);
      check($sformatf("up_qcc_e%0d", k), int'(dqcc[0]), (k == 10) ? 0 : 1);
    end
    en[0] = 1'b0;

    // Down from 0: 9, 8
    ld_n[0] = 1'b0; d[0] = 4'd0;
    edge_wait();
    ld_n[0] = 1'b1;
    check("dn_load_q", int'(dq[0]), 0);
    en[0] = 1'b1; m[0] = 1'b0;
    edge_wait();
    check("dn_q9",   int'(dq[0]),   9);
    check("dn_qcc9", int'(dqcc[0]), 0);
    edge_wait();
    check("dn_q8",   int'(dq[0]),   8);
    check("dn_qcc8", int'(dqcc[0]), 1);
    en[0] = 1'b0; m[0] = 1'b1;

    // Saturate: load 7, up 5 edges -> 8,9,9,9,9
    ld_n[1] = 1'b0; d[1] = 4'd7;
    edge_wait();
    ld_n[1] = 1'b1; en[1] = 1'b1; ci[1] = 1'b1; m[1] = 1'b1;
    exp_q   = '{8, 9, 9, 9, 9};
    exp_qcc = '{1, 1, 0, 0, 0};
    for (int k = 0; k < 5; k++) begin
      edge_wait();
      check($sformatf("sat_q_e%0d", k),   int'(dq[1]),   exp_q[k]);
      check($sformatf("sat_qcc_e%0d", k), int'(dqcc[1]), exp_qcc[k]);
      check($sformatf("sat_co_e%0d", k),  int'(dco[1]),  (exp_q[k] == 9) ? 1 : 0);
    end
    // Saturate at the bottom: 11 down edges from 9 end held at 0
    m[1] = 1'b0;
    for (int k = 0; k < 11; k++) edge_wait();
    check("satdn_q",   int'(dq[1]),   0);
    check("satdn_co",  int'(dco[1]),  1);
    check("satdn_qcc", int'(dqcc[1]), 0);
    en[1] = 1'b0;

    // Out-of-range load clamps to 9; load beats a pending wrap
    ld_n[0] = 1'b0; d[0] = 4'd12;
    edge_wait();
    check("ld12_q",   int'(dq[0]),   9);
    check("ld12_qcc", int'(dqcc[0]), 1);
    d[0] = 4'd3; en[0] = 1'b1; ci[0] = 1'b1; m[0] = 1'b1;
    edge_wait();
    check("ldpri_q",   int'(dq[0]),   3);
    check("ldpri_qcc", int'(dqcc[0]), 1);
    ld_n[0] = 1'b1; en[0] = 1'b0;

    // Full-width modulus 16: 15 -> 0 -> 15 -> 0
    ld_n[3] = 1'b0; d[3] = 4'd15;
    edge_wait();
    check("f_ld_q", int'(dq[3]), 15);
    ld_n[3] = 1'b1; en[3] = 1'b1; ci[3] = 1'b1; m[3] = 1'b1;
    edge_wait();
    check("f_up_q",   int'(dq[3]),   0);
    check("f_up_qcc", int'(dqcc[3]), 0);
    m[3] = 1'b0;
    edge_wait();
    check("f_dn_q",   int'(dq[3]),   15);
    check("f_dn_qcc", int'(dqcc[3]), 0);
    m[3] = 1'b1;
    edge_wait();
    check("f_up2_q", int'(dq[3]), 0);
    en[3] = 1'b0;

    // Asynchronous clear mid-cycle
    ld_n[2] = 1'b0; d[2] = 4'd5;
    edge_wait();
    ld_n[2] = 1'b1;
    check("clr_pre_q", int'(dq[2]), 5);
    clr_n = 1'b0;
    #1;
    check("clr_q2",   int'(dq[2]),   2);
    check("clr_qcc2", int'(dqcc[2]), 1);
    check("clr_q3",   int'(dq[3]),   0);
    check("clr_qcc3", int'(dqcc[3]), 1);
    en[2] = 1'b1; ci[2] = 1'b1; m[2] = 1'b1;
    edge_wait();
    check("clr_hold_q2", int'(dq[2]), 2);
    clr_n = 1'b1;
    edge_wait();
    check("clr_rel_q2", int'(dq[2]), 3);
    en[2] = 1'b0;

    // Two-digit cascade 00..99, 00
    en[4] = 1'b1; ci[4] = 1'b1; m[4] = 1'b1;
    en[5] = 1'b1; m[5] = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      edge_wait();
      check($sformatf("chain_e%0d", k), 10 * int'(dq[5]) + int'(dq[4]), k % 100);
    end
    en[4] = 1'b0; en[5] = 1'b0;
    edge_wait();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_updown_modcounter
`default_nettype wire
